shop_term_if: RTL and testbench
===============================

// Module: shop_term_if
// PURPOSE
//  Host-side terminal front end for the shop command core. Assembles an incoming ASCII byte
//  stream into right-justified command words and drives the core's i_a/i_u/i_rdy inputs.
//  After each issued command it samples the core's o_a response word and serializes it back
//  out as bytes, followed by CR LF. It sits between a UART/testbench byte channel and shop_v.
// PARAMETERS
//  I_A_NUM_ASCII_CHARS  7    max chars per command token (width of o_a word / 8)
//  O_A_NUM_ASCII_CHARS  9    chars in core response word
//  I_U_NUM_BITS         4    width of numeric user field o_u
//  RESP_WAIT            3    cycles from o_rdy pulse to sampling i_shop_a (1..15)
//  TERM_CHAR            8'h0D  end-of-token char (CR); 8'h0A (LF) always ignored on rx
// PORTS
//  i_clk        in   1                  clock
//  i_reset      in   1                  synchronous, active-high reset
//  i_rx_data    in   8                  incoming ASCII byte
//  i_rx_valid   in   1                  i_rx_data valid
//  o_rx_ready   out  1                  byte accepted when i_rx_valid & o_rx_ready
//  o_tx_data    out  8                  outgoing ASCII byte
//  o_tx_valid   out  1                  o_tx_data valid
//  i_tx_ready   in   1                  byte consumed when o_tx_valid & i_tx_ready
//  o_a          out  I_A_NUM_ASCII_CHARS*8  command word to core (i_a)
//  o_u          out  I_U_NUM_BITS       numeric token value to core (i_u)
//  o_rdy        out  1                  1-cycle command strobe to core (i_rdy)
//  i_shop_a     in   O_A_NUM_ASCII_CHARS*8  core response word (o_a)
//  o_err        out  1                  1-cycle pulse: token too long, discarded
// BEHAVIOUR
//  Reset: all outputs 0; state COLLECT; token buffer, char count, digit accumulator cleared.
//  Reset mid-operation is honoured in any state; o_tx_valid is 0 the cycle after reset.
//  States: COLLECT -> ISSUE -> WAIT -> SEND -> SEND_CR -> SEND_LF -> COLLECT.
//  COLLECT: o_rx_ready=1. Accepted byte handling:
//   - 8'h0A: dropped.
//   - TERM_CHAR with count==0: dropped (empty line), stay COLLECT.
//   - TERM_CHAR with overflow flag set: o_err=1 next cycle, clear buffer, stay COLLECT.
//   - TERM_CHAR otherwise: go ISSUE.
//   - other: if count<I_A_NUM_ASCII_CHARS, buf <= {buf[W-9:0], byte}, count++; else set overflow.
//   - digit accumulator: acc = acc*10 + (byte-"0") while all chars are '0'..'9',
//     saturating at 2**I_U_NUM_BITS-1; any non-digit clears the all-digit flag.
//  ISSUE (1 cycle): o_a <= buf (zero-padded high bytes, matching Verilog string literals);
//   o_u <= all-digit ? acc : 0; o_rdy=1 this cycle only; buffer/count/acc cleared.
//   o_a and o_u hold until the next ISSUE. o_rx_ready=0 from ISSUE through SEND_LF.
//  WAIT: count RESP_WAIT cycles after the o_rdy cycle, then latch i_shop_a into tx shift reg.
//  SEND: emit bytes MSB-first, skipping leading 8'h00 bytes; an all-zero word emits nothing.
//   Embedded zeros after the first non-zero byte are sent as-is.
//  SEND_CR / SEND_LF: emit 8'h0D then 8'h0A.
//  Tx handshake: o_tx_data stable while o_tx_valid & !i_tx_ready; advance only on the
//   handshake cycle. o_tx_valid may be asserted back-to-back (one byte/cycle when ready).
//  Latency: TERM_CHAR accepted at cycle N -> o_rdy at N+1 -> i_shop_a sampled at
//   N+1+RESP_WAIT -> first tx byte valid the following cycle.
//  Rx bytes offered while o_rx_ready=0 are not consumed (sender must hold).
// TESTING
//  1. rx "B","u","y",0x0D -> one o_rdy pulse; o_a=56'h00000000_427579; o_u=0; o_err=0.
//  2. i_shop_a="Cmd?" at sample -> tx 43,6D,64,3F,0D,0A exactly; no 00 bytes; back to COLLECT.
//  3. same as 2 with i_tx_ready low 5 cycles after first byte -> o_tx_data held 8'h6D, no loss/dup.
//  4. rx "AddItemX",0x0D (8 chars) -> no o_rdy; o_err pulses once; next "Buy",0x0D issues normally.
//  5. rx "12",0x0D -> o_u=12; rx "99",0x0D -> o_u=15; rx 0x0D,0x0A alone -> no o_rdy.
//  6. i_reset mid-SEND -> o_tx_valid=0 next cycle, o_rx_ready=1 after release, o_a=0.

Source files
------------

// File: rtl/shop_term_if.sv
// shop_term_if: host-side terminal front end for the shop command core.
//
// Turns an ASCII byte stream into right-justified command words for the core.
// After each command it samples the core's response word and sends it back as
// bytes followed by CR LF.
//
// Ports
//   i_clk, i_reset          clock and synchronous active-high reset
//   i_rx_data/valid, o_rx_ready   incoming byte channel (valid/ready)
//   o_tx_data/valid, i_tx_ready   outgoing byte channel (valid/ready)
//   o_a, o_u, o_rdy         command word, numeric value and 1-cycle strobe to the core
//   i_shop_a                core response word
//   o_err                   1-cycle pulse when an over-long token is discarded
module shop_term_if #(
    parameter int         I_A_NUM_ASCII_CHARS = 7,
    parameter int         O_A_NUM_ASCII_CHARS = 9,
    parameter int         I_U_NUM_BITS        = 4,
    parameter int         RESP_WAIT           = 3,
    parameter logic [7:0] TERM_CHAR           = 8'h0D
) (
    input  logic                             i_clk,
    input  logic                             i_reset,
    input  logic [7:0]                       i_rx_data,
    input  logic                             i_rx_valid,
    output logic                             o_rx_ready,
    output logic [7:0]                       o_tx_data,
    output logic                             o_tx_valid,
    input  logic                             i_tx_ready,
    output logic [I_A_NUM_ASCII_CHARS*8-1:0] o_a,
    output logic [I_U_NUM_BITS-1:0]          o_u,
    output logic                             o_rdy,
    input  logic [O_A_NUM_ASCII_CHARS*8-1:0] i_shop_a,
    output logic                             o_err
);
    localparam int AW    = I_A_NUM_ASCII_CHARS * 8;
    localparam int RW    = O_A_NUM_ASCII_CHARS * 8;
    localparam int CW    = $clog2(I_A_NUM_ASCII_CHARS + 1);
    localparam int NW    = $clog2(O_A_NUM_ASCII_CHARS + 1);
    localparam int ACC_W = I_U_NUM_BITS + 4;
    localparam logic [I_U_NUM_BITS-1:0] U_MAX = '1;

    typedef enum logic [2:0] {
        S_COLLECT, S_ISSUE, S_WAIT, S_SEND, S_SEND_CR, S_SEND_LF
    } state_t;

    state_t state, state_nxt;

    logic [AW-1:0]           tok_buf;
    logic [CW-1:0]           tok_cnt;
    logic                    tok_ovf;
    logic [I_U_NUM_BITS-1:0] acc;
    logic                    all_dig;
    logic [3:0]              wait_cnt;
    logic [RW-1:0]           tx_sh;
    logic [NW-1:0]           tx_left;

    // Rx byte classification.
    logic rx_fire, is_lf, is_term, is_dig;
    assign rx_fire = i_rx_valid && (state == S_COLLECT);
    assign is_lf   = (i_rx_data == 8'h0A);
    assign is_term = (i_rx_data == TERM_CHAR);
    assign is_dig  = (i_rx_data >= 8'h30) && (i_rx_data <= 8'h39);

    // Decimal accumulate with saturation; headroom of 4 bits covers acc*10+9.
    logic [ACC_W-1:0]        acc_sum;
    logic [I_U_NUM_BITS-1:0] acc_nxt;
    assign acc_sum = ACC_W'(acc) * ACC_W'(10) + ACC_W'(i_rx_data[3:0]);
    assign acc_nxt = (acc_sum > ACC_W'(U_MAX)) ? U_MAX : acc_sum[I_U_NUM_BITS-1:0];

    // Number of significant response bytes (highest non-zero byte + 1), and the
    // response shifted so the first significant byte sits at the top of the shifter.
    logic [NW-1:0] resp_n;
    logic [RW-1:0] resp_norm;
    always_comb begin
        resp_n = '0;
        for (int i = 0; i < O_A_NUM_ASCII_CHARS; i++)
            if (i_shop_a[i*8 +: 8] != 8'h00) resp_n = NW'(i + 1);
    end
    assign resp_norm = i_shop_a << ((O_A_NUM_ASCII_CHARS - int'(resp_n)) * 8);

    logic wait_done;
    assign wait_done = (wait_cnt == 4'(RESP_WAIT - 1));

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_COLLECT;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt  = state;
        o_rx_ready = 1'b0;
        o_tx_valid = 1'b0;
        o_tx_data  = 8'h00;
        o_rdy      = 1'b0;
        case (state)
            S_COLLECT: begin
                o_rx_ready = !i_reset;
                if (rx_fire && is_term && !is_lf && tok_cnt != '0 && !tok_ovf)
                    state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                o_rdy     = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // An all-zero response goes straight to the line terminator.
                if (wait_done) state_nxt = (resp_n == '0) ? S_SEND_CR : S_SEND;
            end
            S_SEND: begin
                o_tx_valid = 1'b1;
                o_tx_data  = tx_sh[RW-1 -: 8];
                if (i_tx_ready && tx_left == NW'(1)) state_nxt = S_SEND_CR;
            end
            S_SEND_CR: begin
                o_tx_valid = 1'b1;
                o_tx_data  = 8'h0D;
                if (i_tx_ready) state_nxt = S_SEND_LF;
            end
            S_SEND_LF: begin
                o_tx_valid = 1'b1;
                o_tx_data  = 8'h0A;
                if (i_tx_ready) state_nxt = S_COLLECT;
            end
            default: state_nxt = S_COLLECT;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tok_buf  <= '0;
            tok_cnt  <= '0;
            tok_ovf  <= 1'b0;
            acc      <= '0;
            all_dig  <= 1'b1;
            wait_cnt <= '0;
            tx_sh    <= '0;
            tx_left  <= '0;
            o_a      <= '0;
            o_u      <= '0;
            o_err    <= 1'b0;
        end else begin
            o_err <= 1'b0;
            case (state)
                S_COLLECT: begin
                    if (rx_fire && !is_lf) begin
                        if (is_term) begin
                            if (tok_cnt != '0) begin
                                // Command word is loaded on the terminator edge so it is
                                // already stable during the o_rdy cycle.
                                if (!tok_ovf) begin
                                    o_a <= tok_buf;
                                    o_u <= all_dig ? acc : '0;
                                end
                                o_err   <= tok_ovf;
                                tok_buf <= '0;
                                tok_cnt <= '0;
                                tok_ovf <= 1'b0;
                                acc     <= '0;
                                all_dig <= 1'b1;
                            end
                        end else begin
                            if (tok_cnt < CW'(I_A_NUM_ASCII_CHARS)) begin
                                tok_buf <= {tok_buf[AW-9:0], i_rx_data};
                                tok_cnt <= tok_cnt + 1'b1;
                            end else begin
                                tok_ovf <= 1'b1;
                            end
                            if (!is_dig)      all_dig <= 1'b0;
                            else if (all_dig) acc     <= acc_nxt;
                        end
                    end
                end
                S_ISSUE: wait_cnt <= '0;
                S_WAIT: begin
                    wait_cnt <= wait_cnt + 1'b1;
                    if (wait_done) begin
                        tx_sh   <= resp_norm;
                        tx_left <= resp_n;
                    end
                end
                S_SEND: begin
                    if (i_tx_ready) begin
                        tx_sh   <= tx_sh << 8;
                        tx_left <= tx_left - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_shop_term_if.sv
module tb_shop_term_if;
    localparam int NA    = 7;
    localparam int NR    = 9;
    localparam int NU    = 4;
    localparam int RWAIT = 3;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [NA*8-1:0] a;
        logic [NU-1:0]   u;
    } cmd_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [7:0]      i_rx_data;
    logic            i_rx_valid;
    logic            o_rx_ready;
    logic [7:0]      o_tx_data;
    logic            o_tx_valid;
    logic            i_tx_ready;
    logic [NA*8-1:0] o_a;
    logic [NU-1:0]   o_u;
    logic            o_rdy;
    logic [NR*8-1:0] i_shop_a;
    logic            o_err;

    always #5 clk = ~clk;

    shop_term_if #(
        .I_A_NUM_ASCII_CHARS(NA), .O_A_NUM_ASCII_CHARS(NR),
        .I_U_NUM_BITS(NU), .RESP_WAIT(RWAIT), .TERM_CHAR(8'h0D)
    ) dut (
        .i_clk(clk), .i_reset(rst),
        .i_rx_data(i_rx_data), .i_rx_valid(i_rx_valid), .o_rx_ready(o_rx_ready),
        .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(i_tx_ready),
        .o_a(o_a), .o_u(o_u), .o_rdy(o_rdy), .i_shop_a(i_shop_a), .o_err(o_err)
    );

    int              n_vec = 0;
    int              n_mis = 0;
    int              cyc   = 0;
    cmd_t            exp_cmd[$];
    logic [7:0]      exp_tx[$];
    logic [NR*8-1:0] resp_q[$];
    int              exp_err     = 0;
    bit              in_rst      = 1'b1;
    bit              stall_first = 1'b0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        n_vec++;
        n_mis++;
        $display("FAIL %s", nm);
    endtask

    function automatic bq_t s2q(input string s);
        bq_t q;
        for (int i = 0; i < s.len(); i++) q.push_back(s[i]);
        return q;
    endfunction

    // Reference model: what one line (token bytes before CR) should produce.
    task automatic expect_token(input bq_t tok, input logic [NR*8-1:0] resp);
        bq_t             clean;
        bit              dig = 1'b1;
        int              val = 0;
        logic [NA*8-1:0] a   = '0;
        bit              started = 1'b0;
        cmd_t            c;
        foreach (tok[i]) if (tok[i] != 8'h0A) clean.push_back(tok[i]);
        if (clean.size() == 0) return;
        if (clean.size() > NA) begin
            exp_err++;
            return;
        end
        foreach (clean[i]) begin
            a = a * 256 + (NA*8)'(clean[i]);
            if (clean[i] >= 8'h30 && clean[i] <= 8'h39) val = val * 10 + int'(clean[i] - 8'h30);
            else dig = 1'b0;
        end
        c.a = a;
        c.u = dig ? NU'((val > 15) ? 15 : val) : '0;
        exp_cmd.push_back(c);
        resp_q.push_back(resp);
        for (int i = NR - 1; i >= 0; i--) begin
            if (resp[i*8 +: 8] != 8'h00) started = 1'b1;
            if (started) exp_tx.push_back(resp[i*8 +: 8]);
        end
        exp_tx.push_back(8'h0D);
        exp_tx.push_back(8'h0A);
    endtask

    // Called at a negedge; returns at a negedge after the byte was accepted.
    task automatic send_byte(input logic [7:0] b);
        int t = 0;
        i_rx_data  = b;
        i_rx_valid = 1'b1;
        while (!o_rx_ready && t < 500) begin
            @(negedge clk);
            t++;
        end
        if (t >= 500) fail_now("rx_timeout");
        @(posedge clk);
        @(negedge clk);
        i_rx_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
    endtask

    task automatic send_token(input bq_t tok, input logic [NR*8-1:0] resp);
        expect_token(tok, resp);
        foreach (tok[i]) send_byte(tok[i]);
        send_byte(8'h0D);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_cmd.size() != 0 || exp_tx.size() != 0 || exp_err != 0) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check("drain", 128'(exp_cmd.size() + exp_tx.size() + exp_err), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    // Core model: response word is only valid during the single cycle in which
    // the front end is supposed to sample it; its complement otherwise.
    initial begin
        int              cnt = 0;
        logic [NR*8-1:0] cur = '0;
        i_shop_a = '1;
        forever begin
            @(negedge clk);
            if (in_rst) begin
                cnt      = 0;
                i_shop_a = ~cur;
            end else if (o_rdy) begin
                cur      = (resp_q.size() != 0) ? resp_q.pop_front() : '0;
                cnt      = RWAIT;
                i_shop_a = ~cur;
            end else if (cnt > 1) begin
                cnt--;
            end else if (cnt == 1) begin
                cnt      = 0;
                i_shop_a = cur;
            end else begin
                i_shop_a = ~cur;
            end
        end
    end

    // Monitor: also owns i_tx_ready so handshake decisions are made in one place.
    initial begin
        bit         hold = 1'b0;
        logic [7:0] hold_data = '0;
        bit         first_pend = 1'b0;
        int         rdy_cyc = 0;
        int         stall_n = 0;
        cmd_t       c;
        i_tx_ready = 1'b1;
        forever begin
            @(negedge clk);
            cyc++;
            if (in_rst) begin
                hold       = 1'b0;
                first_pend = 1'b0;
                stall_n    = 0;
            end else begin
                if (stall_n > 0) begin
                    i_tx_ready = 1'b0;
                    stall_n--;
                end else begin
                    i_tx_ready = ($urandom_range(0, 3) != 0);
                end
                if (hold) check("tx_hold", {o_tx_valid, o_tx_data}, {1'b1, hold_data});
                if (o_rdy) begin
                    if (exp_cmd.size() == 0) fail_now("unexpected_rdy");
                    else begin
                        c = exp_cmd.pop_front();
                        check("o_a", o_a, c.a);
                        check("o_u", o_u, c.u);
                    end
                    rdy_cyc    = cyc;
                    first_pend = 1'b1;
                end
                if (o_tx_valid && first_pend) begin
                    check("latency", 128'(cyc - rdy_cyc), 128'(RWAIT + 1));
                    first_pend = 1'b0;
                end
                if (o_tx_valid && i_tx_ready) begin
                    if (exp_tx.size() == 0) fail_now("unexpected_tx");
                    else check("tx_byte", o_tx_data, exp_tx.pop_front());
                    if (stall_first) begin
                        stall_first = 1'b0;
                        stall_n     = 5;
                    end
                end
                hold      = o_tx_valid && !i_tx_ready;
                hold_data = o_tx_data;
                if (o_err) begin
                    check("err_expected", 128'(exp_err > 0), 128'(1));
                    if (exp_err > 0) exp_err--;
                end
            end
        end
    end

    initial begin
        bq_t             tok;
        logic [NR*8-1:0] r;
        int              n, t;
        rst        = 1'b1;
        i_rx_valid = 1'b0;
        i_rx_data  = 8'h00;
        repeat (3) @(negedge clk);
        check("rst_o_a", o_a, 0);
        check("rst_o_u", o_u, 0);
        check("rst_o_rdy", o_rdy, 0);
        check("rst_o_err", o_err, 0);
        check("rst_tx_valid", o_tx_valid, 0);
        check("rst_rx_ready", o_rx_ready, 0);
        rst    = 1'b0;
        in_rst = 1'b0;
        @(negedge clk);
        check("rx_ready_after_rst", o_rx_ready, 1);

        // Basic command with a stall right after the first response byte.
        stall_first = 1'b1;
        send_token(s2q("Buy"), 72'h436D643F);
        wait_idle();
        check("buy_o_a_held", o_a, 56'h427579);
        check("buy_o_u_held", o_u, 0);

        // Over-long token is discarded, then a normal command.
        send_token(s2q("AddItemX"), 72'h11);
        send_token(s2q("Buy"), 72'h436D643F);
        wait_idle();

        // Numeric values, saturation, empty lines.
        send_token(s2q("12"), 72'h4F4B);
        wait_idle();
        check("u_12", o_u, 12);
        send_token(s2q("99"), 72'h4F4B);
        wait_idle();
        check("u_sat", o_u, 15);
        send_byte(8'h0D);
        send_byte(8'h0D);
        send_byte(8'h0A);
        repeat (10) @(negedge clk);

        // Exact-length token, embedded LF, embedded zeros and all-zero response.
        send_token(s2q("1234567"), 72'h00_0000_4100_42);
        tok = s2q("A");
        tok.push_back(8'h0A);
        tok.push_back(8'h42);
        send_token(tok, '0);
        send_token(s2q("x"), 72'h41_4243_4445_4647_4849);
        wait_idle();

        // Random lines.
        for (int k = 0; k < 40; k++) begin
            tok.delete();
            n = $urandom_range(0, 9);
            for (int j = 0; j < n; j++) begin
                case ($urandom_range(0, 9))
                    0:       tok.push_back(8'h0A);
                    1, 2, 3, 4: tok.push_back(8'(8'h30 + $urandom_range(0, 9)));
                    default: tok.push_back(8'($urandom_range(8'h20, 8'h7E)));
                endcase
            end
            r = {8'($urandom), 32'($urandom), 32'($urandom)};
            n = $urandom_range(0, 9);
            if (n < 9) r = r & ((72'd1 << (8 * n)) - 72'd1);
            send_token(tok, r);
        end
        wait_idle();

        // Reset in the middle of sending a response.
        send_token(s2q("Q"), 72'h41_4243_4445_4647_4849);
        t = 0;
        while (!o_tx_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        check("tx_started", o_tx_valid, 1);
        @(negedge clk);
        rst    = 1'b1;
        in_rst = 1'b1;
        @(negedge clk);
        check("midrst_tx_valid", o_tx_valid, 0);
        check("midrst_o_a", o_a, 0);
        check("midrst_o_u", o_u, 0);
        exp_cmd.delete();
        exp_tx.delete();
        resp_q.delete();
        exp_err = 0;
        rst    = 1'b0;
        in_rst = 1'b0;
        @(negedge clk);
        check("midrst_rx_ready", o_rx_ready, 1);
        check("midrst_tx_idle", o_tx_valid, 0);

        send_token(s2q("7"), 72'h4F4B);
        wait_idle();
        check("post_rst_u", o_u, 7);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end
endmodule
